snoop_buffer_arbiter: RTL and testbench
=======================================

Name: snoop_buffer_arbiter

Overview:
- Owns a pool of NUM_BUFS packet buffers that are shared between one AXI-Stream snooper (the producer) and one filter engine (the consumer).
- Offers a free buffer to the snooper over the rdy_for_sn / rdy_for_sn_ack handshake.
- When the snooper signals sn_done, queues that buffer in completion order.
- Dispatches queued buffers to the filter, and returns each buffer to the free pool when the filter reports done.
- Sits between the snooper's buffer-select mux and the filter core's read-side mux.

Parameters:
- NUM_BUFS, 4, number of packet buffers; must be a power of 2 and at least 2.
- SEL_WIDTH, 2, width of a buffer index; equals log2(NUM_BUFS).
- CNT_WIDTH, 16, width of the dispatched-packet counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rdy_for_sn  output  1  a free buffer is offered to the snooper.
- rdy_for_sn_ack  input  1  snooper accepts the offered buffer.
- sn_done  input  1  snooper finished writing its active buffer (1-cycle pulse).
- sn_buf_sel  output  SEL_WIDTH  buffer offered to, or owned by, the snooper.
- flt_rdy  input  1  filter is idle and can take a packet.
- flt_start  output  1  1-cycle pulse: the filter now owns flt_buf_sel.
- flt_buf_sel  output  SEL_WIDTH  buffer handed to the filter; registered and held until the next flt_start.
- flt_done  input  1  filter finished with buffer flt_done_buf (1-cycle pulse).
- flt_done_buf  input  SEL_WIDTH  index of the buffer being released.
- ready_count  output  SEL_WIDTH+1  number of buffers queued for the filter.
- pkt_count  output  CNT_WIDTH  packets dispatched to the filter; wraps modulo 2^CNT_WIDTH.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Per-buffer state, 2 bits each: FREE, SNOOP, READY, FILTER.
- Reset (rst low, asynchronous):
  - every buffer is FREE and the ready FIFO is empty;
  - rdy_for_sn, flt_start, err are 0;
  - sn_buf_sel, flt_buf_sel, ready_count, pkt_count are 0;
  - the snooper FSM is in SN_IDLE.
  - Reset asserted mid-operation discards all ownership; in-flight snooper and filter activity must be reset by the same rst.
- Snooper FSM:
  - SN_IDLE: if any buffer is FREE, latch the lowest-index FREE buffer into sn_buf_sel and go to SN_OFFER. Otherwise stay in SN_IDLE with rdy_for_sn=0.
  - SN_OFFER: rdy_for_sn=1 and sn_buf_sel stays stable. On rdy_for_sn_ack=1 the buffer becomes SNOOP, the FSM goes to SN_ACTIVE, and rdy_for_sn=0 from the next cycle.
  - SN_ACTIVE: rdy_for_sn=0. On sn_done the buffer becomes READY, its index is pushed to the ready FIFO, and the FSM goes to SN_IDLE.
  - sn_done outside SN_ACTIVE is ignored and sets err.
- Latency:
  - Out of reset, rdy_for_sn rises on the 2nd clock edge.
  - After sn_done, the next offer appears 2 cycles later if a buffer is free.
- Ready FIFO:
  - Depth NUM_BUFS, holds buffer indices.
  - Cannot overflow: a buffer is in the FIFO at most once.
  - ready_count is the FIFO occupancy.
- Dispatch:
  - If the FIFO is non-empty and flt_rdy=1 in cycle N, then in cycle N+1: flt_start=1 for exactly one cycle, flt_buf_sel = FIFO head, the head is popped, the buffer becomes FILTER, and pkt_count increments.
  - No dispatch is made in the cycle flt_start is high; the filter must drop flt_rdy after flt_start.
- Release:
  - flt_done with flt_done_buf in state FILTER sets that buffer to FREE next cycle.
  - flt_done naming a buffer not in FILTER is ignored and sets err.
- Simultaneous events:
  - sn_done, flt_done, and a FIFO push and pop in the same cycle are all honoured.
  - Push and pop together leave ready_count unchanged.
  - A buffer freed in cycle N is visible to the SN_IDLE search from cycle N+1.
  - A push into an empty FIFO can be dispatched no earlier than the following cycle; there is no FIFO bypass.
- Starvation (all buffers READY or FILTER): the snooper FSM waits in SN_IDLE. The snooper's own drop logic handles the incoming packets.
- err clears only on reset.

Decomposition:
- Shared package snoop_arb_pkg:
  - buffer-state encoding (FREE=0, SNOOP=1, READY=2, FILTER=3);
  - snooper FSM state encoding.
- One sub-module, arb_idx_fifo: a synchronous index FIFO of depth NUM_BUFS, width SEL_WIDTH, with push/pop, count, empty and full outputs.

Test Plan:
- Reset release, flt_rdy=0, snooper acks each offer and pulses sn_done 5 cycles later:
  - offers come in order 0,1,2,3;
  - ready_count reaches 4;
  - rdy_for_sn stays 0 after the 4th sn_done.
- With 4 buffers queued, set flt_rdy=1 and pulse flt_done for each granted buffer after 3 cycles:
  - flt_start pulses with flt_buf_sel 0,1,2,3 in completion order;
  - pkt_count=4.
- Snooper completes buffers 2 then 0, with buffers 1 and 3 held in FILTER by the filter:
  - dispatch order is 2 then 0, not lowest-index first.
- sn_done and flt_done(buf 1) in the same cycle, with ready_count=2 and a pop also in that cycle:
  - ready_count stays 2;
  - buffer 1 is offered to the snooper 2 cycles later.
- flt_done_buf=3 while buffer 3 is FREE:
  - err=1 and stays 1;
  - buffer states are unchanged.
- Assert rst low mid-SN_ACTIVE with 2 buffers queued:
  - all outputs are 0 immediately, without a clock;
  - after release, buffer 0 is offered again.

Source files
------------

// File: rtl/snoop_arb_pkg.sv
// Shared encodings for the snoop buffer arbiter: per-buffer ownership and snooper FSM states.
package snoop_arb_pkg;

  typedef enum logic [1:0] {
    BUF_FREE   = 2'd0,
    BUF_SNOOP  = 2'd1,
    BUF_READY  = 2'd2,
    BUF_FILTER = 2'd3
  } buf_state_t;

  typedef enum logic [1:0] {
    SN_IDLE   = 2'd0,
    SN_OFFER  = 2'd1,
    SN_ACTIVE = 2'd2
  } sn_state_t;

endpackage

// File: rtl/arb_idx_fifo.sv
// Synchronous FIFO of buffer indices; depth must be a power of two so the pointers wrap naturally.
module arb_idx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_idx,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_idx;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/snoop_buffer_arbiter.sv
// Hands packet buffers from a free pool to the snooper, queues completed ones in order,
// dispatches them to the filter and returns them to the pool when the filter releases them.
module snoop_buffer_arbiter #(
  parameter int NUM_BUFS  = 4,
  parameter int SEL_WIDTH = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 rdy_for_sn,
  input  logic                 rdy_for_sn_ack,
  input  logic                 sn_done,
  output logic [SEL_WIDTH-1:0] sn_buf_sel,
  input  logic                 flt_rdy,
  output logic                 flt_start,
  output logic [SEL_WIDTH-1:0] flt_buf_sel,
  input  logic                 flt_done,
  input  logic [SEL_WIDTH-1:0] flt_done_buf,
  output logic [SEL_WIDTH:0]   ready_count,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic                 err
);

  import snoop_arb_pkg::*;

  buf_state_t           buf_st  [NUM_BUFS];
  buf_state_t           buf_nxt [NUM_BUFS];
  sn_state_t            sn_st;
  logic                 init_done;
  logic                 any_free;
  logic [SEL_WIDTH-1:0] free_idx;
  logic                 sn_ack;
  logic                 sn_fin;
  logic                 rel_ok;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [SEL_WIDTH-1:0] fifo_head;
  logic                 fifo_empty;
  logic                 fifo_full;

  assign rdy_for_sn = (sn_st == SN_OFFER);
  assign sn_ack     = (sn_st == SN_OFFER) && rdy_for_sn_ack;
  assign sn_fin     = (sn_st == SN_ACTIVE) && sn_done;
  assign rel_ok     = flt_done && (buf_st[flt_done_buf] == BUF_FILTER);
  assign fifo_push  = sn_fin && !fifo_full;
  // flt_start high blocks a second dispatch before the filter has dropped flt_rdy
  assign fifo_pop   = !fifo_empty && flt_rdy && !flt_start;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < NUM_BUFS; i++) begin
      if (!any_free && buf_st[i] == BUF_FREE) begin
        any_free = 1'b1;
        free_idx = SEL_WIDTH'(i);
      end
    end
  end

  // Each event targets a buffer in a distinct state, so no two can collide on one index
  always_comb begin
    buf_nxt = buf_st;
    if (sn_ack)   buf_nxt[sn_buf_sel]   = BUF_SNOOP;
    if (sn_fin)   buf_nxt[sn_buf_sel]   = BUF_READY;
    if (fifo_pop) buf_nxt[fifo_head]    = BUF_FILTER;
    if (rel_ok)   buf_nxt[flt_done_buf] = BUF_FREE;
  end

  arb_idx_fifo #(
    .DEPTH (NUM_BUFS),
    .WIDTH (SEL_WIDTH)
  ) u_ready_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_idx (sn_buf_sel),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (ready_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // init_done holds off the first free-buffer search so the first offer lands on the 2nd edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_BUFS; i++) begin
        buf_st[i] <= BUF_FREE;
      end
      sn_st       <= SN_IDLE;
      init_done   <= 1'b0;
      sn_buf_sel  <= '0;
      flt_start   <= 1'b0;
      flt_buf_sel <= '0;
      pkt_count   <= '0;
      err         <= 1'b0;
    end else begin
      buf_st    <= buf_nxt;
      init_done <= 1'b1;
      flt_start <= fifo_pop;
      if (fifo_pop) begin
        flt_buf_sel <= fifo_head;
        pkt_count   <= pkt_count + 1'b1;
      end
      if ((sn_done && sn_st != SN_ACTIVE) || (flt_done && !rel_ok)) begin
        err <= 1'b1;
      end
      case (sn_st)
        SN_IDLE: begin
          if (init_done && any_free) begin
            sn_buf_sel <= free_idx;
            sn_st      <= SN_OFFER;
          end
        end
        SN_OFFER: begin
          if (rdy_for_sn_ack) sn_st <= SN_ACTIVE;
        end
        SN_ACTIVE: begin
          if (sn_done) sn_st <= SN_IDLE;
        end
        default: sn_st <= SN_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_buffer_arbiter.sv
// Bench for snoop_buffer_arbiter: cycle table, directed multi-cycle sequences, random traffic vs a queue model.
module tb_snoop_buffer_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy_for_sn;
  logic        rdy_for_sn_ack;
  logic        sn_done;
  logic [1:0]  sn_buf_sel;
  logic        flt_rdy;
  logic        flt_start;
  logic [1:0]  flt_buf_sel;
  logic        flt_done;
  logic [1:0]  flt_done_buf;
  logic [2:0]  ready_count;
  logic [15:0] pkt_count;
  logic        err;

  int total = 0;
  int bad   = 0;

  snoop_buffer_arbiter #(
    .NUM_BUFS  (4),
    .SEL_WIDTH (2),
    .CNT_WIDTH (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy_for_sn     (rdy_for_sn),
    .rdy_for_sn_ack (rdy_for_sn_ack),
    .sn_done        (sn_done),
    .sn_buf_sel     (sn_buf_sel),
    .flt_rdy        (flt_rdy),
    .flt_start      (flt_start),
    .flt_buf_sel    (flt_buf_sel),
    .flt_done       (flt_done),
    .flt_done_buf   (flt_done_buf),
    .ready_count    (ready_count),
    .pkt_count      (pkt_count),
    .err            (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       ack;
    logic       snd;
    logic       frdy;
    logic       fdone;
    logic [1:0] fbuf;
    logic       e_rdy;
    logic [1:0] e_sel;
    logic       e_fs;
    logic [1:0] e_fsel;
    logic [2:0] e_rc;
    int         e_pkt;
    logic       e_err;
  } vec_t;

  vec_t vecs [14];

  // Reference model: buffer ownership array plus a completion-order queue
  int m_st [4];   // 0 free, 1 snoop, 2 ready, 3 filter
  int m_q [$];
  int m_ph;       // 0 waiting, 1 offering, 2 snooper busy
  int m_sel, m_init, m_fs, m_fsel, m_pkt, m_err;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input int r, input int s, input int fs, input int fsel,
                          input int rc, input int pkt, input int e);
    chk({tag, ".rdy_for_sn"}, int'(rdy_for_sn), r);
    chk({tag, ".sn_buf_sel"}, int'(sn_buf_sel), s);
    chk({tag, ".flt_start"}, int'(flt_start), fs);
    chk({tag, ".flt_buf_sel"}, int'(flt_buf_sel), fsel);
    chk({tag, ".ready_count"}, int'(ready_count), rc);
    chk({tag, ".pkt_count"}, int'(pkt_count), pkt);
    chk({tag, ".err"}, int'(err), e);
  endtask

  task automatic idle_inputs();
    rdy_for_sn_ack = 1'b0;
    sn_done        = 1'b0;
    flt_rdy        = 1'b0;
    flt_done       = 1'b0;
    flt_done_buf   = 2'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic take_offer(input string tag, output int idx);
    for (int i = 0; i < 30 && !rdy_for_sn; i++) @(negedge clk);
    chk({tag, ".offer_wait"}, int'(rdy_for_sn), 1);
    idx = int'(sn_buf_sel);
    rdy_for_sn_ack = 1'b1;
    @(negedge clk);
    rdy_for_sn_ack = 1'b0;
  endtask

  task automatic finish_snoop(input int hold);
    repeat (hold - 1) @(negedge clk);
    sn_done = 1'b1;
    @(negedge clk);
    sn_done = 1'b0;
  endtask

  task automatic snoop_one(input string tag, input int hold, input int exp_idx);
    int idx;
    take_offer(tag, idx);
    chk({tag, ".offer_idx"}, idx, exp_idx);
    finish_snoop(hold);
  endtask

  task automatic dispatch_one(input string tag, input int exp_idx);
    flt_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (flt_start) break;
    end
    chk({tag, ".start_wait"}, int'(flt_start), 1);
    chk({tag, ".flt_buf_sel"}, int'(flt_buf_sel), exp_idx);
    flt_rdy = 1'b0;
  endtask

  task automatic release_buf(input int b);
    flt_done     = 1'b1;
    flt_done_buf = 2'(b);
    @(negedge clk);
    flt_done = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_st[i] = 0;
    m_q.delete();
    m_ph = 0; m_sel = 0; m_init = 0; m_fs = 0; m_fsel = 0; m_pkt = 0; m_err = 0;
  endtask

  task automatic model_step(input bit ack, input bit snd, input bit frdy, input bit fdone, input int fbuf);
    int  lowest_free;
    bit  take, fin, disp, rel;
    int  h;
    lowest_free = -1;
    for (int i = 3; i >= 0; i--) if (m_st[i] == 0) lowest_free = i;
    take = (m_ph == 1) && ack;
    fin  = (m_ph == 2) && snd;
    disp = (m_q.size() > 0) && frdy && (m_fs == 0);
    rel  = fdone && (m_st[fbuf] == 3);
    if ((snd && m_ph != 2) || (fdone && !rel)) m_err = 1;
    if (rel) m_st[fbuf] = 0;
    m_fs = disp ? 1 : 0;
    if (disp) begin
      h = m_q.pop_front();
      m_st[h] = 3;
      m_fsel  = h;
      m_pkt   = (m_pkt + 1) % 65536;
    end
    if (fin) begin
      m_st[m_sel] = 2;
      m_q.push_back(m_sel);
      m_ph = 0;
    end else if (take) begin
      m_st[m_sel] = 1;
      m_ph = 2;
    end else if (m_ph == 0 && m_init == 1 && lowest_free >= 0) begin
      m_sel = lowest_free;
      m_ph  = 1;
    end
    m_init = 1;
  endtask

  initial begin
    int idx;
    int flt_list [4];
    int nflt;
    bit r_ack, r_snd, r_frdy, r_fdone;
    int r_fbuf;

    rst = 1'b1;
    idle_inputs();
    @(negedge clk);

    // ---- cycle table from reset ----
    vecs[0]  = '{0,0,0,0,2'd0, 0,2'd0,0,2'd0,3'd0,0,0};
    vecs[1]  = '{0,0,0,0,2'd0, 1,2'd0,0,2'd0,3'd0,0,0};
    vecs[2]  = '{1,0,0,0,2'd0, 0,2'd0,0,2'd0,3'd0,0,0};
    vecs[3]  = '{0,0,0,0,2'd0, 0,2'd0,0,2'd0,3'd0,0,0};
    vecs[4]  = '{0,1,0,0,2'd0, 0,2'd0,0,2'd0,3'd1,0,0};
    vecs[5]  = '{0,0,1,0,2'd0, 1,2'd1,1,2'd0,3'd0,1,0};
    vecs[6]  = '{1,0,0,0,2'd0, 0,2'd1,0,2'd0,3'd0,1,0};
    vecs[7]  = '{0,0,0,1,2'd0, 0,2'd1,0,2'd0,3'd0,1,0};
    vecs[8]  = '{0,1,0,0,2'd0, 0,2'd1,0,2'd0,3'd1,1,0};
    vecs[9]  = '{0,0,1,0,2'd0, 1,2'd0,1,2'd1,3'd0,2,0};
    vecs[10] = '{0,0,1,0,2'd0, 1,2'd0,0,2'd1,3'd0,2,0};
    vecs[11] = '{0,0,0,1,2'd2, 1,2'd0,0,2'd1,3'd0,2,1};
    vecs[12] = '{0,1,0,0,2'd0, 1,2'd0,0,2'd1,3'd0,2,1};
    vecs[13] = '{1,0,0,1,2'd1, 0,2'd0,0,2'd1,3'd0,2,1};

    do_reset();
    chk_outs("reset", 0, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 14; r++) begin
      rdy_for_sn_ack = vecs[r].ack;
      sn_done        = vecs[r].snd;
      flt_rdy        = vecs[r].frdy;
      flt_done       = vecs[r].fdone;
      flt_done_buf   = vecs[r].fbuf;
      @(negedge clk);
      chk_outs($sformatf("vec%0d", r), int'(vecs[r].e_rdy), int'(vecs[r].e_sel), int'(vecs[r].e_fs),
               int'(vecs[r].e_fsel), int'(vecs[r].e_rc), vecs[r].e_pkt, int'(vecs[r].e_err));
    end

    // ---- fill all four buffers, then drain in completion order ----
    do_reset();
    for (int k = 0; k < 4; k++) snoop_one($sformatf("fill%0d", k), 5, k);
    chk("fill.ready_count", int'(ready_count), 4);
    for (int i = 0; i < 6; i++) begin
      chk("starve.rdy_for_sn", int'(rdy_for_sn), 0);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      dispatch_one($sformatf("drain%0d", k), k);
      repeat (2) @(negedge clk);
      release_buf(k);
    end
    chk("drain.pkt_count", int'(pkt_count), 4);
    chk("drain.ready_count", int'(ready_count), 0);

    // ---- completion order 2 then 0 while 1 and 3 stay with the filter ----
    do_reset();
    for (int k = 0; k < 4; k++) snoop_one($sformatf("ord_fill%0d", k), 2, k);
    for (int k = 0; k < 4; k++) dispatch_one($sformatf("ord_hold%0d", k), k);
    release_buf(2);
    snoop_one("ord_sn2", 2, 2);
    release_buf(0);
    snoop_one("ord_sn0", 2, 0);
    chk("ord.ready_count", int'(ready_count), 2);
    dispatch_one("ord_first", 2);
    dispatch_one("ord_second", 0);
    chk("ord.pkt_count", int'(pkt_count), 6);

    // ---- sn_done, flt_done and push+pop in one cycle ----
    do_reset();
    snoop_one("sim_a", 2, 0);
    snoop_one("sim_b", 2, 1);
    dispatch_one("sim_d0", 0);
    dispatch_one("sim_d1", 1);
    snoop_one("sim_c", 2, 2);
    snoop_one("sim_e", 2, 3);
    release_buf(0);
    take_offer("sim_f", idx);
    chk("sim.offer_idx", idx, 0);
    chk("sim.ready_count_before", int'(ready_count), 2);
    sn_done = 1'b1; flt_done = 1'b1; flt_done_buf = 2'd1; flt_rdy = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("sim.ready_count", int'(ready_count), 2);
    chk("sim.flt_start", int'(flt_start), 1);
    chk("sim.flt_buf_sel", int'(flt_buf_sel), 2);
    chk("sim.rdy_next", int'(rdy_for_sn), 0);
    @(negedge clk);
    chk("sim.rdy_late", int'(rdy_for_sn), 1);
    chk("sim.sel_late", int'(sn_buf_sel), 1);

    // ---- release of a FREE buffer flags err and changes nothing ----
    do_reset();
    repeat (3) @(negedge clk);
    release_buf(3);
    chk("bad_rel.err", int'(err), 1);
    for (int k = 0; k < 4; k++) snoop_one($sformatf("bad_rel_sn%0d", k), 2, k);
    chk("bad_rel.err_sticky", int'(err), 1);
    chk("bad_rel.ready_count", int'(ready_count), 4);

    // ---- asynchronous reset while snooping with two buffers queued ----
    do_reset();
    for (int k = 0; k < 3; k++) snoop_one($sformatf("ar_fill%0d", k), 2, k);
    dispatch_one("ar_d0", 0);
    dispatch_one("ar_d1", 1);
    snoop_one("ar_sn3", 2, 3);
    release_buf(0);
    take_offer("ar_act", idx);
    chk("ar.offer_idx", idx, 0);
    chk("ar.ready_count_before", int'(ready_count), 2);
    chk("ar.pkt_before", int'(pkt_count), 2);
    #2 rst = 1'b0;
    #1 chk_outs("async_rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    take_offer("ar_after", idx);
    chk("ar.reoffer_idx", idx, 0);
    chk("ar.ready_count_after", int'(ready_count), 0);

    // ---- random traffic against the reference model ----
    do_reset();
    model_reset();
    for (int c = 0; c < 3000 && bad < 40; c++) begin
      chk_outs("rand", (m_ph == 1) ? 1 : 0, m_sel, m_fs, m_fsel, m_q.size(), m_pkt, m_err);
      nflt = 0;
      for (int i = 0; i < 4; i++) if (m_st[i] == 3) begin flt_list[nflt] = i; nflt++; end
      r_ack   = ($urandom_range(0, 1) == 1);
      r_snd   = (m_ph == 2) && ($urandom_range(0, 3) == 0);
      r_frdy  = ($urandom_range(0, 1) == 1);
      r_fdone = (nflt > 0) && ($urandom_range(0, 2) == 0);
      r_fbuf  = (nflt > 0) ? flt_list[$urandom_range(0, nflt - 1)] : 0;
      if (c > 2700 && $urandom_range(0, 49) == 0) begin
        r_fdone = 1'b1;
        r_fbuf  = $urandom_range(0, 3);
        r_snd   = ($urandom_range(0, 1) == 1);
      end
      rdy_for_sn_ack = r_ack;
      sn_done        = r_snd;
      flt_rdy        = r_frdy;
      flt_done       = r_fdone;
      flt_done_buf   = 2'(r_fbuf);
      model_step(r_ack, r_snd, r_frdy, r_fdone, r_fbuf);
      @(negedge clk);
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
